// File: rtl/preg_free_list.sv
// -----------------------------------------------------------------------------
// preg_free_list
//
// Rename-stage free list of physical register tags. It is a circular queue of
// DEPTH tags, one allocation and one release per cycle at most. The allocation
// head can be rolled back to a checkpointed pointer on a branch mispredict, so
// the list recovers together with the register file's ready-table restore.
//
// Pointers are {wrap, idx}. idx counts 0..DEPTH-1 and wrap toggles each lap, so
// DEPTH need not be a power of two.
//
// Ports
//   clk               clock
//   reset             synchronous active-low reset
//   alloc_req         rename requests one tag this cycle
//   alloc_valid       alloc_preg holds a usable tag (not empty, no mispredict)
//   alloc_preg        tag at the head of the list (combinational offer)
//   free_valid        commit releases a tag this cycle
//   free_preg         tag being released (p0 is ignored)
//   mispredict        branch mispredict recovery this cycle
//   checkpoint_valid  restore_head is valid
//   restore_head      checkpointed head pointer {wrap, idx}
//   head_snapshot     registered head pointer, saved into branch checkpoints
//   free_count        number of free tags, 0..DEPTH
//   empty             free_count == 0
//   overflow_err      sticky: a release was dropped because the list was full
// -----------------------------------------------------------------------------
module preg_free_list #(
  parameter int unsigned NUM_PREGS = 128,
  parameter int unsigned NUM_AREGS = 32,
  parameter int unsigned DEPTH     = NUM_PREGS - NUM_AREGS,
  localparam int unsigned TAG_W    = $clog2(NUM_PREGS),
  localparam int unsigned PTR_W    = TAG_W + 1,
  localparam int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc_req,
  output logic             alloc_valid,
  output logic [TAG_W-1:0] alloc_preg,
  input  logic             free_valid,
  input  logic [TAG_W-1:0] free_preg,
  input  logic             mispredict,
  input  logic             checkpoint_valid,
  input  logic [PTR_W-1:0] restore_head,
  output logic [PTR_W-1:0] head_snapshot,
  output logic [CNT_W-1:0] free_count,
  output logic             empty,
  output logic             overflow_err
);

  localparam logic [TAG_W-1:0] LAST_IDX = TAG_W'(DEPTH - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [TAG_W-1:0] entry_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic             overflow_q, overflow_d;

  // Pointer field views
  logic             head_wrap, tail_wrap;
  logic [TAG_W-1:0] head_idx, tail_idx;

  assign head_wrap = head_q[PTR_W-1];
  assign head_idx  = head_q[TAG_W-1:0];
  assign tail_wrap = tail_q[PTR_W-1];
  assign tail_idx  = tail_q[TAG_W-1:0];

  // Advance a {wrap, idx} pointer by one slot around a DEPTH-entry ring.
  function automatic logic [PTR_W-1:0] ptr_incr(input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] nxt;
    if (ptr[TAG_W-1:0] == LAST_IDX) begin
      nxt = {~ptr[PTR_W-1], {TAG_W{1'b0}}};
    end else begin
      nxt = {ptr[PTR_W-1], ptr[TAG_W-1:0] + TAG_W'(1)};
    end
    return nxt;
  endfunction

  // ---------------------------------------------------------------------------
  // Occupancy, all derived from the registered pointers
  // ---------------------------------------------------------------------------
  logic             full;
  logic [PTR_W-1:0] count_raw;

  assign empty = (head_q == tail_q);
  assign full  = (head_idx == tail_idx) && (head_wrap != tail_wrap);

  always_comb begin
    // Modular subtraction; adding DEPTH when the laps differ brings the result
    // back into 0..DEPTH.
    count_raw = {1'b0, tail_idx} - {1'b0, head_idx};
    if (head_wrap != tail_wrap) begin
      count_raw = count_raw + PTR_W'(DEPTH);
    end
  end

  assign free_count = count_raw[CNT_W-1:0];

  // ---------------------------------------------------------------------------
  // Allocation side
  // ---------------------------------------------------------------------------
  logic alloc_fire;

  assign alloc_preg    = entry_q[head_idx];
  assign alloc_valid   = !empty && !mispredict;
  assign alloc_fire    = alloc_req && alloc_valid;
  assign head_snapshot = head_q;

  always_comb begin
    head_d = head_q;
    if (mispredict) begin
      // Without a checkpoint the head simply holds; alloc_valid is already low.
      if (checkpoint_valid) begin
        head_d = restore_head;
      end
    end else if (alloc_fire) begin
      head_d = ptr_incr(head_q);
    end
  end

  // ---------------------------------------------------------------------------
  // Release side
  // ---------------------------------------------------------------------------
  logic free_live;
  logic free_accept;
  logic free_drop;

  // p0 is an architectural mapping and never returns to the list.
  assign free_live = free_valid && (free_preg != '0);

  // When full, a same-cycle allocation vacates the head slot, which is the
  // slot the tail writes. The head entry was already offered combinationally
  // this cycle, so overwriting it at the edge is safe.
  assign free_accept = free_live && (!full || alloc_fire);
  assign free_drop   = free_live && full && !alloc_fire;

  always_comb begin
    tail_d = tail_q;
    if (free_accept) begin
      tail_d = ptr_incr(tail_q);
    end
  end

  always_comb begin
    overflow_d = overflow_q;
    if (free_drop) begin
      overflow_d = 1'b1;
    end
  end

  assign overflow_err = overflow_q;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q     <= '0;
      // Tail one full lap ahead of head: every non-architectural tag is free.
      tail_q     <= {1'b1, {TAG_W{1'b0}}};
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        entry_q[i] <= TAG_W'(int'(NUM_AREGS) + i);
      end
    end else if (free_accept) begin
      entry_q[tail_idx] <= free_preg;
    end
  end

endmodule

// File: tb/tb_preg_free_list.sv
module tb_preg_free_list;

  logic       clk;
  logic       reset;
  logic       alloc_req;
  logic       alloc_valid;
  logic [6:0] alloc_preg;
  logic       free_valid;
  logic [6:0] free_preg;
  logic       mispredict;
  logic       checkpoint_valid;
  logic [7:0] restore_head;
  logic [7:0] head_snapshot;
  logic [6:0] free_count;
  logic       empty;
  logic       overflow_err;

  int errors = 0;
  int checks = 0;

  preg_free_list dut (
    .clk              (clk),
    .reset            (reset),
    .alloc_req        (alloc_req),
    .alloc_valid      (alloc_valid),
    .alloc_preg       (alloc_preg),
    .free_valid       (free_valid),
    .free_preg        (free_preg),
    .mispredict       (mispredict),
    .checkpoint_valid (checkpoint_valid),
    .restore_head     (restore_head),
    .head_snapshot    (head_snapshot),
    .free_count       (free_count),
    .empty            (empty),
    .overflow_err     (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic drive_idle();
    alloc_req        = 1'b0;
    free_valid       = 1'b0;
    free_preg        = 7'd0;
    mispredict       = 1'b0;
    checkpoint_valid = 1'b0;
    restore_head     = 8'd0;
  endtask

  // Holds reset low for two edges, releases it at a negedge and leaves #1 slack.
  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (free_count !== 7'd96) begin
      errors++; $display("FAIL reset_count: got %0d expected 96", free_count);
    end
    checks++;
    if (empty !== 1'b0) begin
      errors++; $display("FAIL reset_empty: got %0b expected 0", empty);
    end
    checks++;
    if (alloc_preg !== 7'd32 || alloc_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_head: got preg=%0d valid=%0b expected 32/1", alloc_preg, alloc_valid);
    end
    checks++;
    if (head_snapshot !== 8'h00 || overflow_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ptr: got snap=%0h ovf=%0b expected 0/0", head_snapshot, overflow_err);
    end
  endtask

  task automatic test_alloc();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      alloc_req = 1'b1;
      #1;
      checks++;
      if (alloc_preg !== 7'(32 + i) || alloc_valid !== 1'b1) begin
        errors++;
        $display("FAIL alloc_%0d: got preg=%0d valid=%0b expected %0d/1",
                 i, alloc_preg, alloc_valid, 32 + i);
      end
    end
    @(negedge clk);
    alloc_req = 1'b0;
    #1;
    checks++;
    if (free_count !== 7'd93 || head_snapshot !== 8'd3) begin
      errors++;
      $display("FAIL alloc_count: got count=%0d snap=%0d expected 93/3",
               free_count, head_snapshot);
    end
  endtask

  task automatic test_drain();
    for (int i = 3; i < 96; i++) begin
      @(negedge clk);
      alloc_req = 1'b1;
      #1;
      checks++;
      if (alloc_preg !== 7'(32 + i)) begin
        errors++;
        $display("FAIL drain_%0d: got %0d expected %0d", i, alloc_preg, 32 + i);
      end
    end
    // One more request against an empty list.
    @(negedge clk);
    alloc_req = 1'b1;
    #1;
    checks++;
    if (empty !== 1'b1 || alloc_valid !== 1'b0 || free_count !== 7'd0) begin
      errors++;
      $display("FAIL drain_empty: got empty=%0b valid=%0b count=%0d expected 1/0/0",
               empty, alloc_valid, free_count);
    end
    @(negedge clk);
    alloc_req = 1'b0;
    #1;
    checks++;
    if (head_snapshot !== 8'h80) begin
      errors++; $display("FAIL drain_hold: got snap=%0h expected 80", head_snapshot);
    end
  endtask

  task automatic test_free_empty();
    @(negedge clk);
    free_valid = 1'b1;
    free_preg  = 7'd5;
    #1;
    checks++;
    if (alloc_valid !== 1'b0) begin
      errors++; $display("FAIL free_empty_bypass: got valid=%0b expected 0", alloc_valid);
    end
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if (alloc_preg !== 7'd5 || alloc_valid !== 1'b1 || free_count !== 7'd1) begin
      errors++;
      $display("FAIL free_empty_next: got preg=%0d valid=%0b count=%0d expected 5/1/1",
               alloc_preg, alloc_valid, free_count);
    end
  endtask

  task automatic test_wrap_restore();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      alloc_req = 1'b1;
    end
    @(negedge clk);
    alloc_req = 1'b0;
    #1;
    checks++;
    if (head_snapshot !== 8'd3) begin
      errors++; $display("FAIL restore_snap: got %0d expected 3", head_snapshot);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      alloc_req = 1'b1;
    end
    @(negedge clk);
    alloc_req        = 1'b1;
    mispredict       = 1'b1;
    checkpoint_valid = 1'b1;
    restore_head     = 8'd3;
    free_valid       = 1'b1;
    free_preg        = 7'd40;
    #1;
    checks++;
    if (alloc_valid !== 1'b0) begin
      errors++; $display("FAIL restore_block: got valid=%0b expected 0", alloc_valid);
    end
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if (alloc_preg !== 7'd35 || head_snapshot !== 8'd3) begin
      errors++;
      $display("FAIL restore_head: got preg=%0d snap=%0d expected 35/3",
               alloc_preg, head_snapshot);
    end
    checks++;
    if (free_count !== 7'd94) begin
      errors++; $display("FAIL restore_count: got %0d expected 94", free_count);
    end
  endtask

  task automatic test_full();
    apply_reset();
    @(negedge clk);
    free_valid = 1'b1;
    free_preg  = 7'd0;
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if (free_count !== 7'd96 || overflow_err !== 1'b0) begin
      errors++;
      $display("FAIL full_p0: got count=%0d ovf=%0b expected 96/0", free_count, overflow_err);
    end
    @(negedge clk);
    free_valid = 1'b1;
    free_preg  = 7'd60;
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if (free_count !== 7'd96 || overflow_err !== 1'b1) begin
      errors++;
      $display("FAIL full_drop: got count=%0d ovf=%0b expected 96/1", free_count, overflow_err);
    end
    // Alloc and free together while full.
    @(negedge clk);
    alloc_req  = 1'b1;
    free_valid = 1'b1;
    free_preg  = 7'd60;
    #1;
    checks++;
    if (alloc_preg !== 7'd32 || alloc_valid !== 1'b1) begin
      errors++;
      $display("FAIL full_swap_offer: got preg=%0d valid=%0b expected 32/1",
               alloc_preg, alloc_valid);
    end
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if (free_count !== 7'd96 || head_snapshot !== 8'd1 || overflow_err !== 1'b1) begin
      errors++;
      $display("FAIL full_swap: got count=%0d snap=%0d ovf=%0b expected 96/1/1",
               free_count, head_snapshot, overflow_err);
    end
    // Drain to the slot the swap overwrote.
    for (int i = 1; i < 96; i++) begin
      @(negedge clk);
      alloc_req = 1'b1;
    end
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if (alloc_preg !== 7'd60 || free_count !== 7'd1 || head_snapshot !== 8'h80) begin
      errors++;
      $display("FAIL full_written: got preg=%0d count=%0d snap=%0h expected 60/1/80",
               alloc_preg, free_count, head_snapshot);
    end
  endtask

  task automatic test_mispredict_nocp();
    @(negedge clk);
    alloc_req        = 1'b1;
    mispredict       = 1'b1;
    checkpoint_valid = 1'b0;
    restore_head     = 8'h05;
    #1;
    checks++;
    if (alloc_valid !== 1'b0) begin
      errors++; $display("FAIL nocp_block: got valid=%0b expected 0", alloc_valid);
    end
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if (head_snapshot !== 8'h80 || free_count !== 7'd1 || alloc_preg !== 7'd60) begin
      errors++;
      $display("FAIL nocp_hold: got snap=%0h count=%0d preg=%0d expected 80/1/60",
               head_snapshot, free_count, alloc_preg);
    end
    checks++;
    if (overflow_err !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky: got %0b expected 1", overflow_err);
    end
  endtask

  task automatic test_reset_midop();
    apply_reset();
    checks++;
    if (overflow_err !== 1'b0 || free_count !== 7'd96 || alloc_preg !== 7'd32) begin
      errors++;
      $display("FAIL midop_reset: got ovf=%0b count=%0d preg=%0d expected 0/96/32",
               overflow_err, free_count, alloc_preg);
    end
  endtask

  initial begin
    reset = 1'b0;
    drive_idle();
    test_reset();
    test_alloc();
    test_drain();
    test_free_empty();
    test_wrap_restore();
    test_full();
    test_mispredict_nocp();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/preg_free_list.md
Name: preg_free_list

Overview:
- Rename-stage free list of physical registers; sits directly upstream of physical_registers.
- Supplies one free physical register tag per cycle to rename; that tag becomes the rd whose ready bit is cleared in the register file.
- Reclaims tags released at commit.
- On mispredict, rolls the allocation head back to a checkpointed pointer, so the free list recovers in step with the register file's ready-table restore.

Parameters:
- NUM_PREGS, 128, total physical registers; tags are 7 bits.
- NUM_AREGS, 32, architectural registers; p0..p31 are mapped at reset and are never in the list.
- DEPTH, NUM_PREGS-NUM_AREGS (96), free-list capacity; need not be a power of two.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk).
- alloc_req  in  1  rename requests one tag this cycle.
- alloc_valid  out  1  tag on alloc_preg is valid.
- alloc_preg  out  7  tag at the head of the list.
- free_valid  in  1  commit releases a tag.
- free_preg  in  7  tag being released.
- mispredict  in  1  branch mispredict recovery this cycle.
- checkpoint_valid  in  1  restore_head is valid.
- restore_head  in  8  checkpointed head pointer, {wrap, idx[6:0]}.
- head_snapshot  out  8  current head pointer, saved into the branch checkpoint.
- free_count  out  7  number of free tags, 0..96.
- empty  out  1  free_count==0.
- overflow_err  out  1  sticky error: a free was dropped because the list was full.

Behaviour:
- Storage: DEPTH entries of 7 bits, circular.
  - head and tail pointers are {wrap, idx}.
  - Increment: if idx==DEPTH-1, idx becomes 0 and wrap toggles; otherwise idx+1.
- Occupancy:
  - free_count = tail.idx-head.idx, plus DEPTH when the wrap bits differ.
  - empty when head==tail.
  - full when the idx fields are equal and the wrap bits differ.
  - free_count, empty and full are combinational from the registered pointers.
- Reset (reset==0 at posedge):
  - entry[i]=NUM_AREGS+i; head=0; tail={1,0} (full); overflow_err=0.
  - Resulting outputs: free_count=96, empty=0, alloc_preg=32, head_snapshot=0.
  - Reset mid-operation discards all state.
- Allocation:
  - alloc_preg = entry[head.idx], combinational.
  - alloc_valid = !empty && !mispredict, combinational.
  - Fire = alloc_req && alloc_valid; on fire, head increments at posedge.
  - alloc_req with alloc_valid=0 is a no-op.
  - Zero-latency offer: the tag is visible the same cycle as the request.
- Free:
  - If free_valid && free_preg!=0 and the list is not full, or an allocation fires in the same cycle: write entry[tail.idx]=free_preg and increment tail.
  - free_preg==0 is silently ignored.
  - free_valid while full with no concurrent fire: the free is dropped and overflow_err is set; it is cleared only by reset.
  - No same-cycle bypass: a tag freed while empty appears on alloc_preg the next cycle.
- Simultaneous alloc and free when full:
  - Both occur; the entry is read combinationally before the write at the edge.
- Mispredict:
  - alloc_valid is forced 0, so no allocation fires.
  - If checkpoint_valid: head <= restore_head.
  - A concurrent free is still applied (commits are older than the branch).
  - mispredict with checkpoint_valid=0: head is unchanged.
  - Restored occupancy must satisfy free_count<=DEPTH; violating this is a caller error.
- head_snapshot: equals the registered head, i.e. the head before this cycle's allocation.
  - The checkpoint for a branch taken in the same cycle as an allocation therefore excludes that allocation; the caller selects accordingly.
- Protocol: at most one alloc and one free per cycle; no other handshake.

Test Plan:
- Reset low for 2 cycles, then high; alloc_req=1 for 3 cycles -> alloc_preg 32,33,34 with alloc_valid=1; free_count 96->93.
- Allocate 96 consecutive tags -> last alloc_preg=127; then empty=1, alloc_valid=0, free_count=0; a further alloc_req leaves head unchanged.
- While empty, free_preg=5 -> that cycle alloc_valid=0; next cycle alloc_preg=5, alloc_valid=1, free_count=1.
- Wrap and restore:
  - Allocate 3 tags and capture head_snapshot=3.
  - Allocate 4 more tags.
  - Assert mispredict with checkpoint_valid=1, restore_head=3, plus a concurrent free of 40.
  - Required: alloc_valid=0 that cycle; next cycle alloc_preg=35.
  - Required: free_count=96-7+4+1=94, with a wrapped tail.
- Full list:
  - free_preg=0 -> ignored, no change.
  - free_preg=60 -> dropped, overflow_err=1, stays 1 until reset.
  - free_preg=60 with concurrent alloc fire -> accepted, free_count stays 96.
- Mispredict with checkpoint_valid=0 and alloc_req=1 -> head unchanged, no alloc fire, alloc_valid=0.
